// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and one-entry skid.
// in_ready comes from registered state only, so back-pressure is cut here.
module pipe_skid_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign out_data  = main_q;
  assign level     = state;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Flush behaves like reset; a concurrent input transfer is dropped.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= BUSY;
            main_q <= in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state  <= FULL;
            skid_q <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state  <= BUSY;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus random traffic
// compared against a two-entry FIFO queue model.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  level;

  int errs = 0;
  int checks = 0;

  logic [31:0] mq[$];
  logic [31:0] mlast = '0;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH(32),
    .RESET_VAL(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .level(level)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] d,
                      input logic ordy, input logic fl,
                      input logic r);
    logic        inf;
    logic        outf;
    logic        hold;
    logic [31:0] pv;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    inf  = iv && (mq.size() < 2);
    outf = ordy && (mq.size() > 0);
    hold = out_valid && !ordy;
    pv   = out_data;
    @(posedge clk);
    if (r || fl) begin
      mq.delete();
      mlast = '0;
    end else begin
      if (outf) mlast = mq.pop_front();
      if (inf) mq.push_back(d);
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    check("level", 32'(level), 32'(mq.size()));
    check("out_data", out_data, (mq.size() != 0) ? mq[0] : mlast);
    if (hold && !r && !fl) begin
      check("stable_data", out_data, pv);
      check("stable_valid", 32'(out_valid), 32'd1);
    end
  endtask

  initial begin
    // Reset with garbage on the input
    step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_data", out_data, 32'h0);

    // Streaming
    step(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
    check("s1", out_data, 32'h1);
    step(1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
    check("s2", out_data, 32'h2);
    check("s2_level", 32'(level), 32'd1);
    step(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
    check("s3", out_data, 32'h3);
    check("s3_ready", 32'(in_ready), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("s_empty", 32'(out_valid), 32'd0);

    // Back-pressure
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    check("bp_level", 32'(level), 32'd2);
    check("bp_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
      check("bp_hold", out_data, 32'hA);
    end

    // Drain: A, B, then C
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    check("dr_b", out_data, 32'hB);
    check("dr_lvl", 32'(level), 32'd1);
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    check("dr_c", out_data, 32'hC);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("dr_empty", 32'(level), 32'd0);

    // Flush while full
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hE, 1'b0, 1'b1, 1'b0);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_level", 32'(level), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_data", out_data, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("fl_noE", 32'(out_valid), 32'd0);

    // Random traffic against the queue model
    for (int i = 0; i < 1000; i++) begin
      step(($urandom % 4) != 0, $urandom,
           1'($urandom % 2), ($urandom % 64) == 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
